// File: rtl/dcache.sv
// Direct-mapped write-through data cache, one 32-bit word per line, in front of a
// fixed-latency backing store. Read hits finish combinationally; misses and writes stall.
module dcache #(
    parameter int DEPTH    = 64,
    parameter int LINES    = 8,
    parameter int MISS_LAT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        r_w,
    input  logic        MStrobe,
    output logic [31:0] mem_out,
    output logic        PCReady,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);
    localparam int AW = $clog2(DEPTH) + 2;
    localparam int IW = $clog2(LINES);
    localparam int TW = AW - 2 - IW;
    localparam int CW = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;

    logic [LINES-1:0] valid;
    logic [TW-1:0]    tags    [LINES];
    logic [31:0]      lines   [LINES];
    logic [31:0]      backing [DEPTH];
    logic [31:0]      out_q;

    // Request latched at IDLE->BUSY so the processor may change its bus mid-transaction
    logic [AW-3:0] req_word;
    logic [31:0]   req_data;
    logic          req_wr;

    logic [AW-3:0] word;
    logic [IW-1:0] idx, r_idx;
    logic [TW-1:0] tag, r_tag;
    logic          hit, r_hit, rd_hit, start, finish;

    // Byte-offset bits and bits above the backing range are deliberately dropped
    logic unused_addr;
    assign unused_addr = ^{mem_addr[31:AW], mem_addr[1:0]};

    assign word  = mem_addr[AW-1:2];
    assign idx   = mem_addr[2+IW-1:2];
    assign tag   = mem_addr[AW-1:2+IW];
    assign r_idx = req_word[IW-1:0];
    assign r_tag = req_word[AW-3:IW];

    assign hit    = valid[idx] && (tags[idx] == tag);
    assign r_hit  = valid[r_idx] && (tags[r_idx] == r_tag);
    assign rd_hit = (state == IDLE) && MStrobe && !r_w && hit;
    assign start  = (state == IDLE) && MStrobe && !(!r_w && hit);
    assign finish = (state == BUSY) && (cnt == '0);

    always_comb begin
        state_nxt = state;
        PCReady   = 1'b1;
        mem_out   = out_q;
        case (state)
            IDLE: begin
                if (rd_hit) begin
                    mem_out = lines[idx];
                end else if (start) begin
                    PCReady   = 1'b0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                PCReady = 1'b0;
                if (cnt == '0) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            valid    <= '0;
            out_q    <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (start)
                cnt <= CW'(MISS_LAT - 1);
            else if (state == BUSY && cnt != '0)
                cnt <= cnt - CW'(1);
            if (rd_hit && hit_cnt != '1)
                hit_cnt <= hit_cnt + 16'd1;
            if (start && !r_w && miss_cnt != '1)
                miss_cnt <= miss_cnt + 16'd1;
            if (finish && !req_wr) begin
                out_q        <= backing[req_word];
                valid[r_idx] <= 1'b1;
            end
        end
    end

    // Storage arrays carry no reset; their updates are still blocked while reset is high
    always_ff @(posedge clk) begin
        if (start) begin
            req_word <= word;
            req_data <= mem_data;
            req_wr   <= r_w;
        end
        if (!reset && finish) begin
            if (!req_wr) begin
                tags[r_idx]  <= r_tag;
                lines[r_idx] <= backing[req_word];
            end else begin
                backing[req_word] <= req_data;
                if (r_hit) lines[r_idx] <= req_data;
            end
        end
    end
endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache (DEPTH=64, LINES=8, MISS_LAT=4): latency, fill,
// write-through, aliasing, request latching, reset abort and counter saturation.
module tb_dcache;
    logic        clk = 1'b0;
    logic        reset, r_w, MStrobe;
    logic [31:0] mem_addr, mem_data, mem_out;
    logic        PCReady;
    logic [15:0] hit_cnt, miss_cnt;
    int          checks = 0;
    int          errors = 0;

    dcache #(.DEPTH(64), .LINES(8), .MISS_LAT(4)) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_data(mem_data),
        .r_w(r_w), .MStrobe(MStrobe), .mem_out(mem_out), .PCReady(PCReady),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // Called at a falling edge; returns the cycle PCReady rose (request cycle = 0)
    // and mem_out in that cycle, then advances to the next falling edge.
    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          output int lat, output logic [31:0] rd);
        mem_addr = addr; mem_data = data; r_w = wr; MStrobe = 1'b1;
        lat = 0;
        #1;
        while (!PCReady && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        if (!PCReady) lat = -1;
        rd = mem_out;
        @(negedge clk);
        MStrobe = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; MStrobe = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (PCReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", PCReady); end
        checks++; if (mem_out !== 32'h0) begin errors++; $display("FAIL reset_out got %h want 0", mem_out); end
        checks++; if (hit_cnt !== 16'd0) begin errors++; $display("FAIL reset_hit got %0d want 0", hit_cnt); end
        checks++; if (miss_cnt !== 16'd0) begin errors++; $display("FAIL reset_miss got %0d want 0", miss_cnt); end
    endtask

    task automatic test_write_miss_read();
        int lat; logic [31:0] rd;
        access(1'b1, 32'h40, 32'hDEADBEEF, lat, rd);
        checks++; if (lat !== 5) begin errors++; $display("FAIL wr_lat got %0d want 5", lat); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_out_hold got %h want 0", rd); end
        checks++; if (miss_cnt !== 16'd0) begin errors++; $display("FAIL wr_nocount got %0d want 0", miss_cnt); end
        access(1'b0, 32'h40, 32'h0, lat, rd);
        checks++; if (lat !== 5) begin errors++; $display("FAIL rdmiss_lat got %0d want 5", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rdmiss_data got %h want deadbeef", rd); end
        checks++; if (miss_cnt !== 16'd1) begin errors++; $display("FAIL rdmiss_cnt got %0d want 1", miss_cnt); end
        access(1'b0, 32'h40, 32'h0, lat, rd);
        checks++; if (lat !== 0) begin errors++; $display("FAIL rdhit_lat got %0d want 0", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rdhit_data got %h want deadbeef", rd); end
        checks++; if (hit_cnt !== 16'd1) begin errors++; $display("FAIL rdhit_cnt got %0d want 1", hit_cnt); end
    endtask

    task automatic test_conflict();
        int lat; logic [31:0] rd;
        logic [31:0] addrs [3] = '{32'h40, 32'h60, 32'h40};
        logic [31:0] exp   [3] = '{32'hDEADBEEF, 32'h60606060, 32'hDEADBEEF};
        access(1'b1, 32'h60, 32'h60606060, lat, rd);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            access(1'b0, addrs[i], 32'h0, lat, rd);
            checks++; if (lat !== 5) begin errors++; $display("FAIL conflict_lat[%0d] got %0d want 5", i, lat); end
            checks++; if (rd !== exp[i]) begin errors++; $display("FAIL conflict_data[%0d] got %h want %h", i, rd, exp[i]); end
        end
        checks++; if (miss_cnt !== 16'd3) begin errors++; $display("FAIL conflict_miss got %0d want 3", miss_cnt); end
        checks++; if (hit_cnt !== 16'd0) begin errors++; $display("FAIL conflict_hit got %0d want 0", hit_cnt); end
    endtask

    task automatic test_write_through();
        int lat; logic [31:0] rd;
        do_reset();
        access(1'b1, 32'h04, 32'hA5A5A5A5, lat, rd);
        access(1'b0, 32'h04, 32'h0, lat, rd);
        checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL wt_fill got %h want a5a5a5a5", rd); end
        access(1'b1, 32'h04, 32'h12345678, lat, rd);
        checks++; if (lat !== 5) begin errors++; $display("FAIL wt_wr_lat got %0d want 5", lat); end
        checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL wt_out_hold got %h want a5a5a5a5", rd); end
        access(1'b0, 32'h04, 32'h0, lat, rd);
        checks++; if (lat !== 0) begin errors++; $display("FAIL wt_hit_lat got %0d want 0", lat); end
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL wt_hit_data got %h want 12345678", rd); end
        access(1'b0, 32'h104, 32'h0, lat, rd);
        checks++; if (lat !== 0) begin errors++; $display("FAIL alias_lat got %0d want 0", lat); end
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL alias_data got %h want 12345678", rd); end
        checks++; if (hit_cnt !== 16'd2) begin errors++; $display("FAIL wt_hits got %0d want 2", hit_cnt); end
    endtask

    task automatic test_latch();
        int lat; logic [31:0] rd;
        do_reset();
        mem_addr = 32'h40; r_w = 1'b0; MStrobe = 1'b1;
        @(negedge clk);
        mem_addr = 32'h60; r_w = 1'b1; mem_data = 32'hFFFFFFFF; MStrobe = 1'b0;
        lat = 1; #1;
        while (!PCReady && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        checks++; if (lat !== 5) begin errors++; $display("FAIL latch_lat got %0d want 5", lat); end
        checks++; if (mem_out !== 32'hDEADBEEF) begin errors++; $display("FAIL latch_data got %h want deadbeef", mem_out); end
        @(negedge clk);
        access(1'b0, 32'h60, 32'h0, lat, rd);
        checks++; if (rd !== 32'h60606060) begin errors++; $display("FAIL latch_nowrite got %h want 60606060", rd); end
        checks++; if (miss_cnt !== 16'd2) begin errors++; $display("FAIL latch_miss got %0d want 2", miss_cnt); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd;
        logic [31:0] addrs [3] = '{32'h40, 32'h104, 32'h40};
        logic [31:0] exp   [3] = '{32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
        do_reset();
        access(1'b0, 32'h40, 32'h0, lat, rd);
        access(1'b0, 32'h04, 32'h0, lat, rd);
        checks++; if (lat !== 5) begin errors++; $display("FAIL after_done_lat got %0d want 5", lat); end
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL after_done_data got %h want 12345678", rd); end
        for (int i = 0; i < 3; i++) begin
            mem_addr = addrs[i]; r_w = 1'b0; MStrobe = 1'b1;
            #1;
            checks++; if (PCReady !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, PCReady); end
            checks++; if (mem_out !== exp[i]) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, mem_out, exp[i]); end
            @(negedge clk);
        end
        MStrobe = 1'b0;
        checks++; if (hit_cnt !== 16'd3) begin errors++; $display("FAIL b2b_hits got %0d want 3", hit_cnt); end
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] rd;
        access(1'b1, 32'h08, 32'h55AA55AA, lat, rd);
        do_reset();
        mem_addr = 32'h08; mem_data = 32'hCAFEF00D; r_w = 1'b1; MStrobe = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; MStrobe = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (PCReady !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", PCReady); end
        checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin errors++; $display("FAIL abort_cnts got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
        access(1'b0, 32'h08, 32'h0, lat, rd);
        checks++; if (lat !== 5) begin errors++; $display("FAIL abort_lat got %0d want 5", lat); end
        checks++; if (rd !== 32'h55AA55AA) begin errors++; $display("FAIL abort_nowrite got %h want 55aa55aa", rd); end
    endtask

    task automatic test_saturate();
        int lat; logic [31:0] rd;
        do_reset();
        access(1'b0, 32'h40, 32'h0, lat, rd);
        mem_addr = 32'h40; r_w = 1'b0; MStrobe = 1'b1;
        repeat (65534) @(negedge clk);
        checks++; if (hit_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h want fffe", hit_cnt); end
        @(negedge clk);
        checks++; if (hit_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_max got %h want ffff", hit_cnt); end
        repeat (4) @(negedge clk);
        checks++; if (hit_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", hit_cnt); end
        checks++; if (miss_cnt !== 16'd1) begin errors++; $display("FAIL sat_miss got %0d want 1", miss_cnt); end
        MStrobe = 1'b0;
    endtask

    initial begin
        reset = 1'b1; MStrobe = 1'b0; r_w = 1'b0; mem_addr = '0; mem_data = '0;
        @(negedge clk);
        test_reset();
        test_write_miss_read();
        test_conflict();
        test_write_through();
        test_latch();
        test_back_to_back();
        test_reset_abort();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 SHALL take parameters:
- DEPTH, 64, backing-memory words.
- LINES, 8, cache lines; one 32-bit word per line; power of 2.
- MISS_LAT, 4, backing-memory access cycles, at least 1.
REQ-002 SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_addr  in  32  byte address from processor ALUOutM.
- mem_data  in  32  store data (WriteDataM).
- r_w  in  1  1=write, 0=read (MemWriteM).
- MStrobe  in  1  access request.
- mem_out  out  32  read data (ReadDataM).
- PCReady  out  1  access complete / no stall; processor holds pipeline while low.
- hit_cnt  out  16  read-hit counter.
- miss_cnt  out  16  read-miss counter.

Function
REQ-003 SHALL derive fields from mem_addr: word address = mem_addr[AW-1:2], with AW=log2(DEPTH)+2; index = mem_addr[2+IW-1:2], with IW=log2(LINES); tag = mem_addr[AW-1:2+IW].
- Bits 1:0 and bits at or above AW SHALL be ignored, so out-of-range addresses wrap.
REQ-004 SHALL keep per line a valid bit, a tag and a 32-bit data word; backing store is a DEPTH x 32 array.
REQ-005 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-006 In IDLE with MStrobe=0: PCReady=1; no state change.
REQ-007 In IDLE with MStrobe=1, r_w=0 and a hit (valid and tag match): PCReady=1 and mem_out=line data, combinationally in the same cycle; remain in IDLE; hit_cnt increments.
REQ-008 In IDLE with MStrobe=1 and a read miss or any write: PCReady=0; next edge enters BUSY with latency counter = MISS_LAT-1; on a read miss, miss_cnt increments at that edge.
REQ-009 In BUSY: PCReady=0; counter decrements each edge; at the edge where counter=0, enter DONE.
REQ-010 At the BUSY->DONE edge:
- read: mem_out is registered with the backing word, and the indexed line is filled (valid=1, tag, data).
- write: the backing word is written with mem_data; if the line hits it is updated too (write-through); a write miss does not allocate.
REQ-011 In DONE: PCReady=1 for exactly one cycle; mem_out holds the fetched word (read) or its prior value (write); next edge returns to IDLE.
REQ-012 Total latency SHALL be: read hit 0 extra cycles; read miss and write PCReady low for MISS_LAT+1 cycles, high on cycle MISS_LAT+1 counted from the request cycle 0.
REQ-013 mem_addr, mem_data and r_w SHALL be sampled only at the IDLE->BUSY edge and latched for the whole transaction; changes during BUSY/DONE are ignored.
REQ-014 MStrobe dropping during BUSY SHALL NOT abort the transaction.
REQ-015 hit_cnt and miss_cnt SHALL saturate at 16'hFFFF and never wrap; writes count in neither.
REQ-016 A new request in the cycle after DONE is serviced normally from IDLE; back-to-back hits complete one per cycle.

Reset
REQ-017 Reset SHALL force: state=IDLE, all valid bits=0, counter=0, mem_out=0, hit_cnt=0, miss_cnt=0, PCReady=1 from the cycle after reset.
REQ-018 Reset asserted in BUSY or DONE SHALL abort the transaction with no backing write and no line fill.
REQ-019 Reset SHALL NOT alter backing-store contents.
REQ-020 Reset has priority over every other event on the same edge.

Verification (DEPTH=64, LINES=8, MISS_LAT=4)
REQ-021 Write 0xDEADBEEF to 0x40 in cycle 0 -> PCReady=0 in cycles 0-4 and =1 in cycle 5; line 0 stays invalid (no allocate).
REQ-022 Read 0x40 after REQ-021 -> miss; PCReady high in cycle 5 with mem_out=0xDEADBEEF; miss_cnt=1. Reread the next cycle -> PCReady=1 in the same cycle, mem_out=0xDEADBEEF, hit_cnt=1.
REQ-023 Conflict: read 0x40, then read 0x60 (same index 0, different tag), then read 0x40 -> three misses, miss_cnt=3, hit_cnt=0.
REQ-024 Write 0x12345678 to a cached address 0x04 -> line updated; the following read hits with 0x12345678; address 0x104 aliases to 0x04 and also hits.
REQ-025 Reset asserted in the 2nd BUSY cycle of a write of 0xCAFEF00D to 0x08 -> no backing write; a later read of 0x08 misses and returns the old value; counters read 0.
REQ-026 Force hit_cnt near 0xFFFF with repeated hits -> it holds at 0xFFFF and does not wrap.
